b07_retta_p: RTL and testbench
==============================

Name: b07_retta_p

Overview:
Parametrised successor of the ITC99-style line-point counter. Scans an internal point memory as consecutive (x, y) word pairs and counts the points that lie on a runtime-programmable line, y + A*x == B, in modulo 2^DATA_W arithmetic. Adds four things over the fixed-function block:
- configurable data, address and count widths;
- a write port for loading the memory;
- latched line coefficients;
- busy, done and saturation status.
It sits in the benchmark suite as a scalable sequential-test target.

Parameters:
DATA_W, 8, width of memory words, x, y and coefficients
ADDR_W, 4, memory address width; depth = 2^ADDR_W words, P = 2^(ADDR_W-1) pairs; ADDR_W >= 1
CNT_W, 8, width of the point counter and the result

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  run request, level-sensitive
coef_a  in  DATA_W  line slope term A, sampled on start acceptance
coef_b  in  DATA_W  line constant B, sampled on start acceptance
wr_en  in  1  memory write strobe
wr_addr  in  ADDR_W  memory write address
wr_data  in  DATA_W  memory write data
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse when the result is updated
sat  out  1  counter saturated during the last scan
punti_retta  out  CNT_W  number of points found by the last completed scan

Behaviour:
- One clock domain; reset is synchronous and active-high. All state is registered; there are no combinational paths from inputs to outputs.
- Reset values:
  - punti_retta=0, busy=0, done=0, sat=0;
  - internal x, y, A, B, cnt and mar = 0;
  - every memory word = 0;
  - state = IDLE.
- Reset has priority over everything, including a write in the same cycle. Reset mid-scan aborts the scan without producing done.
- Memory layout: even address 2k holds x_k; odd address 2k+1 holds y_k; k = 0..P-1.
- Writes:
  - accepted only in IDLE: mem[wr_addr] <= wr_data at that edge;
  - ignored in any other state, so memory is frozen during a scan;
  - an accepted write is visible to a scan started on the same edge.
- States: IDLE, LOAD_X, LOAD_Y, CALC, HOLD.
- IDLE:
  - if start=1: mar<=0, cnt<=0, sat<=0, A<=coef_a, B<=coef_b, busy<=1, go to LOAD_X;
  - otherwise stay in IDLE;
  - punti_retta keeps its last value.
- LOAD_X: x<=mem[mar]; mar<=mar+1; go to LOAD_Y.
- LOAD_Y: y<=mem[mar]; go to CALC.
- CALC:
  - hit = ((A*x + y) mod 2^DATA_W == B), with the product truncated to DATA_W bits;
  - on hit: cnt<=cnt+1, saturating at 2^CNT_W-1; sat<=1 if a hit occurs while cnt is already at maximum;
  - if mar != 2^ADDR_W-1: mar<=mar+1, go to LOAD_X;
  - otherwise: punti_retta <= final count (including this pair's hit), done<=1, busy<=0, go to HOLD.
- HOLD:
  - done<=0;
  - if start=0 go to IDLE; while start stays 1, remain in HOLD;
  - writes are ignored in HOLD.
- Illegal state encodings return to IDLE on the next edge.
- Latency: from the start-acceptance edge, done is high exactly 3*P cycles later (24 cycles with the defaults). done lasts 1 cycle. busy is high for exactly 3*P cycles.
- Changing start, coef_a or coef_b mid-scan has no effect on the scan.

Test Plan:
- Reset, then coef_a=3, coef_b=2, start pulse with memory all zero -> done after 24 cycles, punti_retta=0, sat=0.
- Write the pairs (1,255)(0,0)(0,2)(0,0)(0,2)(255,5)(0,2)(0,2), coef_a=3, coef_b=2, start -> punti_retta=6, done pulses once at cycle 24.
- CNT_W=2, memory all zero, coef_a=0, coef_b=0, start -> all 8 pairs hit; punti_retta=3, sat=1.
- Hold start=1 after done -> FSM stays in HOLD and no second scan starts. Drop start for 1 cycle, then raise it -> new scan, busy=1 again.
- Assert wr_en writing address 1 with data 0 in cycle 5 of the scan with the test-2 data -> write ignored, punti_retta=6. The same write in IDLE, then a rescan -> punti_retta=5.
- Assert reset in cycle 10 of a scan -> busy=0, punti_retta=0, no done, memory zeroed. The next scan with coef_b=0 and coef_a=0 -> punti_retta=8.

Source files
------------

// File: rtl/b07_retta_p.sv
// b07_retta_p: counts memory points (x, y) lying on the line y + A*x == B (mod 2^DATA_W)
//   clock_i        rising-edge clock
//   reset_i        synchronous active-high reset, clears all state and the memory
//   start_i        level-sensitive run request, accepted in IDLE
//   coef_a_i/b_i   line coefficients, latched when a run is accepted
//   wr_en_i/addr/data  memory write port, honoured only in IDLE
//   busy_o         high while a scan is in progress
//   done_o         one-cycle pulse when punti_retta_o is updated
//   sat_o          counter saturated during the last scan
//   punti_retta_o  point count of the last completed scan
module b07_retta_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] coef_a_i,
    input  logic [DATA_W-1:0] coef_b_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_o,
    output logic [CNT_W-1:0]  punti_retta_o
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, CALC, HOLD} state_t;

    state_t state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d, a_q, a_d, b_q, b_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, punti_q, punti_d;
    logic              busy_q, busy_d, done_q, done_d, sat_q, sat_d;
    logic [DATA_W-1:0] lhs;
    logic              hit;

    // product and sum both wrap at DATA_W bits
    assign lhs = a_q * x_q + y_q;
    assign hit = lhs == b_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        a_d     = a_q;
        b_d     = b_q;
        mar_d   = mar_q;
        cnt_d   = cnt_q;
        punti_d = punti_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sat_d   = sat_q;
        case (state_q)
            IDLE: if (start_i) begin
                mar_d   = '0;
                cnt_d   = '0;
                sat_d   = 1'b0;
                a_d     = coef_a_i;
                b_d     = coef_b_i;
                busy_d  = 1'b1;
                state_d = LOAD_X;
            end
            LOAD_X: begin
                x_d     = mem_q[mar_q];
                mar_d   = mar_q + 1'b1;
                state_d = LOAD_Y;
            end
            LOAD_Y: begin
                y_d     = mem_q[mar_q];
                state_d = CALC;
            end
            CALC: begin
                if (hit) begin
                    if (cnt_q == '1) sat_d = 1'b1;
                    else cnt_d = cnt_q + 1'b1;
                end
                if (mar_q != '1) begin
                    mar_d   = mar_q + 1'b1;
                    state_d = LOAD_X;
                end else begin
                    punti_d = cnt_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: state_d = start_i ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mar_q   <= '0;
            cnt_q   <= '0;
            punti_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mar_q   <= mar_d;
            cnt_q   <= cnt_d;
            punti_q <= punti_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    // memory is frozen outside IDLE so a running scan sees a stable image
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en_i && state_q == IDLE) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign sat_o         = sat_q;
    assign punti_retta_o = punti_q;
endmodule

// File: tb/tb_b07_retta_p.sv
// tb_b07_retta_p: directed checks of the line-point counter, default and 2-bit counter builds
module tb_b07_retta_p;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] coef_a = '0;
    logic [7:0] coef_b = '0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy, done, sat, busy2, done2, sat2;
    logic [7:0] punti;
    logic [1:0] punti2;
    int         vec = 0;
    int         miss = 0;

    b07_retta_p dut (
        .clock_i(clk), .reset_i(reset), .start_i(start), .coef_a_i(coef_a), .coef_b_i(coef_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .busy_o(busy), .done_o(done), .sat_o(sat), .punti_retta_o(punti)
    );

    b07_retta_p #(.CNT_W(2)) dut2 (
        .clock_i(clk), .reset_i(reset), .start_i(start), .coef_a_i(coef_a), .coef_b_i(coef_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .busy_o(busy2), .done_o(done2), .sat_o(sat2), .punti_retta_o(punti2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [3:0] addr, input logic [7:0] data);
        wr_en = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // accepts a run, then observes 40 cycles; optional write of mem[1]=0 or reset at cycle n
    task automatic scan(input logic [7:0] a, input logic [7:0] b, input bit hold,
                        input int wr_at, input int rst_at,
                        output int done_at, output int ndone, output int nbusy);
        coef_a = a;
        coef_b = b;
        start = 1'b1;
        done_at = -1;
        ndone = 0;
        nbusy = 0;
        tick();
        if (!hold) start = 1'b0;
        if (busy) nbusy++;
        for (int n = 1; n <= 40; n++) begin
            wr_en = (n == wr_at);
            wr_addr = 4'd1;
            wr_data = 8'd0;
            reset = (n == rst_at);
            tick();
            wr_en = 1'b0;
            reset = 1'b0;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (punti !== 8'd0) begin miss++; $display("FAIL reset_punti got %0d want 0", punti); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if (done !== 1'b0) begin miss++; $display("FAIL reset_done got %b want 0", done); end
        vec++; if (sat !== 1'b0) begin miss++; $display("FAIL reset_sat got %b want 0", sat); end
    endtask

    task automatic test_zero_mem();
        int da, nd, nb;
        scan(8'd3, 8'd2, 1'b0, 0, 0, da, nd, nb);
        vec++; if (da !== 24) begin miss++; $display("FAIL zero_latency got %0d want 24", da); end
        vec++; if (nd !== 1) begin miss++; $display("FAIL zero_ndone got %0d want 1", nd); end
        vec++; if (nb !== 24) begin miss++; $display("FAIL zero_busy_cycles got %0d want 24", nb); end
        vec++; if (punti !== 8'd0) begin miss++; $display("FAIL zero_punti got %0d want 0", punti); end
        vec++; if (sat !== 1'b0) begin miss++; $display("FAIL zero_sat got %b want 0", sat); end
    endtask

    task automatic test_saturation();
        int da, nd, nb;
        scan(8'd0, 8'd0, 1'b0, 0, 0, da, nd, nb);
        vec++; if (da !== 24) begin miss++; $display("FAIL sat_latency got %0d want 24", da); end
        vec++; if (punti !== 8'd8) begin miss++; $display("FAIL sat_punti8 got %0d want 8", punti); end
        vec++; if (sat !== 1'b0) begin miss++; $display("FAIL sat_flag8 got %b want 0", sat); end
        vec++; if (punti2 !== 2'd3) begin miss++; $display("FAIL sat_punti2 got %0d want 3", punti2); end
        vec++; if (sat2 !== 1'b1) begin miss++; $display("FAIL sat_flag2 got %b want 1", sat2); end
    endtask

    task automatic test_points();
        logic [7:0] pts [16] = '{8'd1, 8'd255, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0,
                                 8'd0, 8'd2, 8'd255, 8'd5, 8'd0, 8'd2, 8'd0, 8'd2};
        int da, nd, nb;
        for (int i = 0; i < 16; i++) write_mem(4'(i), pts[i]);
        coef_a = 8'd3;
        coef_b = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        vec++; if (sat2 !== 1'b0) begin miss++; $display("FAIL pts_sat_cleared got %b want 0", sat2); end
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL pts_busy got %b want 1", busy); end
        da = -1;
        nd = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin
                nd++;
                if (da < 0) da = n;
            end
        end
        vec++; if (da !== 24) begin miss++; $display("FAIL pts_latency got %0d want 24", da); end
        vec++; if (nd !== 1) begin miss++; $display("FAIL pts_ndone got %0d want 1", nd); end
        vec++; if (punti !== 8'd6) begin miss++; $display("FAIL pts_punti got %0d want 6", punti); end
        vec++; if (punti2 !== 2'd3) begin miss++; $display("FAIL pts_punti2 got %0d want 3", punti2); end
        vec++; if (sat2 !== 1'b1) begin miss++; $display("FAIL pts_sat2 got %b want 1", sat2); end
    endtask

    task automatic test_hold();
        int da, nd, nb;
        bit got;
        scan(8'd3, 8'd2, 1'b1, 0, 0, da, nd, nb);
        vec++; if (nd !== 1) begin miss++; $display("FAIL hold_ndone got %0d want 1", nd); end
        vec++; if (nb !== 24) begin miss++; $display("FAIL hold_busy_cycles got %0d want 24", nb); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL hold_idle_busy got %b want 0", busy); end
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL hold_restart_busy got %b want 1", busy); end
        got = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            tick();
            got = done;
        end
        vec++; if (!got) begin miss++; $display("FAIL hold_restart_done got 0 want 1"); end
        vec++; if (punti !== 8'd6) begin miss++; $display("FAIL hold_restart_punti got %0d want 6", punti); end
        tick();
    endtask

    task automatic test_write_lock();
        int da, nd, nb;
        bit got;
        scan(8'd3, 8'd2, 1'b0, 5, 0, da, nd, nb);
        vec++; if (punti !== 8'd6) begin miss++; $display("FAIL wr_midscan_punti got %0d want 6", punti); end
        write_mem(4'd1, 8'd0);
        scan(8'd3, 8'd2, 1'b0, 0, 0, da, nd, nb);
        vec++; if (punti !== 8'd5) begin miss++; $display("FAIL wr_idle_punti got %0d want 5", punti); end
        wr_en = 1'b1;
        wr_addr = 4'd1;
        wr_data = 8'd255;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        got = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            tick();
            got = done;
        end
        vec++; if (!got) begin miss++; $display("FAIL wr_same_edge_done got 0 want 1"); end
        vec++; if (punti !== 8'd6) begin miss++; $display("FAIL wr_same_edge_punti got %0d want 6", punti); end
        tick();
    endtask

    task automatic test_reset_midscan();
        int da, nd, nb;
        scan(8'd3, 8'd2, 1'b0, 0, 10, da, nd, nb);
        vec++; if (nd !== 0) begin miss++; $display("FAIL rst_mid_ndone got %0d want 0", nd); end
        vec++; if (nb !== 10) begin miss++; $display("FAIL rst_mid_busy_cycles got %0d want 10", nb); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        vec++; if (punti !== 8'd0) begin miss++; $display("FAIL rst_mid_punti got %0d want 0", punti); end
        scan(8'd0, 8'd0, 1'b0, 0, 0, da, nd, nb);
        vec++; if (da !== 24) begin miss++; $display("FAIL rst_rescan_latency got %0d want 24", da); end
        vec++; if (punti !== 8'd8) begin miss++; $display("FAIL rst_rescan_punti got %0d want 8", punti); end
        vec++; if (sat2 !== 1'b1) begin miss++; $display("FAIL rst_rescan_sat2 got %b want 1", sat2); end
    endtask

    initial begin
        test_reset();
        test_zero_mem();
        test_saturation();
        test_points();
        test_hold();
        test_write_lock();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
